// File: rtl/k005297_pkg.sv
`default_nettype none
// ============================================================================
// Module      : k005297_pkg
// Description : Shared state encoding and default timeout for the Z14 lock
//               supervision timer.
// Revision    : 1.0
// ============================================================================
package k005297_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE  = 2'd0,
        TMR_COUNT = 2'd1,
        TMR_TOVER = 2'd2,
        TMR_WAIT  = 2'd3
    } tmr_state_t;

    localparam int c_TIMEOUT_CNT = 25000;

endpackage
`default_nettype wire

// File: rtl/k005297_snaplatch.sv
`default_nettype none
// ============================================================================
// Module      : k005297_snaplatch
// Description : Snapshot register with valid/ack handshake and sticky overrun.
// Revision    : 1.0
// ============================================================================
module k005297_snaplatch #(
    parameter int DATA_W = 19
) (
    input  logic              i_MCLK,
    input  logic              i_SYS_RST_n,
    input  logic              i_EN,
    input  logic              i_LD,
    input  logic              i_ACK,
    input  logic [DATA_W-1:0] i_DATA,
    output logic [DATA_W-1:0] o_DATA,
    output logic              o_VALID,
    output logic              o_OVR
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_ovr;

    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (i_EN) begin
            if (i_LD) begin
                // A simultaneous ack retires the old snapshot, so only an
                // unacknowledged pending snapshot counts as an overrun.
                r_data  <= i_DATA;
                r_valid <= 1'b1;
                r_ovr   <= r_valid & ~i_ACK;
            end else if (i_ACK && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign o_DATA  = r_data;
    assign o_VALID = r_valid;
    assign o_OVR   = r_ovr;

endmodule
`default_nettype wire

// File: rtl/k005297_timer25k.sv
`default_nettype none
// ============================================================================
// Module      : k005297_timer25k
// Description : Z14 lock supervision timer; fires one timeover strobe after
//               TIMEOUT_CNT locked ticks and snapshots count + CRC MSBs.
// Revision    : 1.0
// ============================================================================
module k005297_timer25k
    import k005297_pkg::*;
#(
    parameter int CNT_W       = 15,
    parameter int TIMEOUT_CNT = c_TIMEOUT_CNT
) (
    input  logic             i_MCLK,
    input  logic             i_SYS_RST_n,
    input  logic             i_CLK2M_PCEN_n,
    input  logic             i_TIMER25K_CNT,
    input  logic             i_TIMER25K_OUTLATCH_LD_n,
    input  logic [3:0]       i_TIMERREG_MSBS,
    input  logic             i_TIMER_CLR_n,
    input  logic             i_LATCH_ACK,
    output logic             o_TIMER25K_TIMEOVER_n,
    output logic [CNT_W-1:0] o_TIMER_LATCH,
    output logic [3:0]       o_MSBS_LATCH,
    output logic             o_LATCH_VALID,
    output logic             o_LATCH_OVR,
    output logic [1:0]       o_TIMER_STATE
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CNT - 1);
    localparam logic [CNT_W-1:0] c_CNT_TOP  = CNT_W'(TIMEOUT_CNT);

    tmr_state_t       r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
    logic             r_tover_n, w_tover_n_nx;
    logic             w_tick;

    assign w_tick = ~i_CLK2M_PCEN_n;

    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            r_state   <= TMR_IDLE;
            r_cnt     <= '0;
            r_tover_n <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_tover_n <= w_tover_n_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_tover_n_nx = r_tover_n;
        if (w_tick) begin
            // The strobe lasts one full tick period, so it only drops on a tick.
            w_tover_n_nx = 1'b1;
            if (!i_TIMER_CLR_n) begin
                w_state_nx = TMR_IDLE;
                w_cnt_nx   = '0;
            end else begin
                unique case (r_state)
                    TMR_IDLE: begin
                        if (i_TIMER25K_CNT) begin
                            w_state_nx = TMR_COUNT;
                            w_cnt_nx   = CNT_W'(1);
                        end
                    end
                    TMR_COUNT: begin
                        if (!i_TIMER25K_CNT) begin
                            w_state_nx = TMR_IDLE;
                            w_cnt_nx   = '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            w_state_nx   = TMR_TOVER;
                            w_cnt_nx     = c_CNT_TOP;
                            w_tover_n_nx = 1'b0;
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end
                    TMR_TOVER: begin
                        w_state_nx = TMR_WAIT;
                    end
                    TMR_WAIT: begin
                        if (!i_TIMER25K_CNT) begin
                            w_state_nx = TMR_IDLE;
                            w_cnt_nx   = '0;
                        end
                    end
                    default: begin
                        w_state_nx = TMR_IDLE;
                        w_cnt_nx   = '0;
                    end
                endcase
            end
        end
    end

    k005297_snaplatch #(
        .DATA_W (CNT_W + 4)
    ) u_snaplatch (
        .i_MCLK      (i_MCLK),
        .i_SYS_RST_n (i_SYS_RST_n),
        .i_EN        (w_tick),
        .i_LD        (~i_TIMER25K_OUTLATCH_LD_n),
        .i_ACK       (i_LATCH_ACK),
        .i_DATA      ({r_cnt, i_TIMERREG_MSBS}),
        .o_DATA      ({o_TIMER_LATCH, o_MSBS_LATCH}),
        .o_VALID     (o_LATCH_VALID),
        .o_OVR       (o_LATCH_OVR)
    );

    assign o_TIMER25K_TIMEOVER_n = r_tover_n;
    assign o_TIMER_STATE         = r_state;

endmodule
`default_nettype wire
